// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/data arbiter for one shared single-port memory, MEM has priority
// Optional IF starvation guard: define MEM_ARBITER_STARVE_GUARD_EN.
module mem_arbiter #(
  parameter int MAX_MEM_STREAK = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ack,
  output logic        if_stall,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_ack,
  output logic        mem_stall,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_ready,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GNT_IF  = 2'd1,
    GNT_MEM = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        w_force_if;
  logic        w_take_if;
  logic        w_take_mem;
  logic        w_done_if;
  logic        w_done_mem;
  logic        r_if_ack;
  logic        r_mem_ack;
  logic        r_bus_we;
  logic [31:0] r_bus_addr;
  logic [31:0] r_bus_wdata;
  logic [31:0] r_if_rdata;
  logic [31:0] r_mem_rdata;

`ifdef MEM_ARBITER_STARVE_GUARD_EN
  localparam int STREAK_W = $clog2(MAX_MEM_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_MEM_STREAK);

  logic [STREAK_W-1:0] r_streak;

  assign w_force_if = if_req && (r_streak == STREAK_MAX);

  // Counts MEM wins over a waiting fetch; saturates until IF gets through.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_streak <= '0;
    end else if (r_state == IDLE) begin
      if (!if_req || w_take_if) begin
        r_streak <= '0;
      end else if (w_take_mem && (r_streak != STREAK_MAX)) begin
        r_streak <= r_streak + 1'b1;
      end
    end
  end
`else
  // Strict MEM priority: IF is never forced ahead.
  assign w_force_if = (MAX_MEM_STREAK < 0);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_force_if)   w_next = GNT_IF;
        else if (mem_req) w_next = GNT_MEM;
        else if (if_req)  w_next = GNT_IF;
      end
      GNT_IF, GNT_MEM: begin
        if (bus_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_take_if  = (r_state == IDLE) && (w_next == GNT_IF);
    w_take_mem = (r_state == IDLE) && (w_next == GNT_MEM);
    w_done_if  = (r_state == GNT_IF) && bus_ready;
    w_done_mem = (r_state == GNT_MEM) && bus_ready;
    bus_req    = (r_state != IDLE);
  end

  // Request fields are captured once at grant so the bus stays stable whatever the requester does.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_if_ack    <= 1'b0;
      r_mem_ack   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_wdata <= '0;
      r_if_rdata  <= '0;
      r_mem_rdata <= '0;
    end else begin
      r_if_ack  <= w_done_if;
      r_mem_ack <= w_done_mem;
      if (w_take_mem) begin
        r_bus_addr  <= mem_addr;
        r_bus_we    <= mem_we;
        r_bus_wdata <= mem_wdata;
      end else if (w_take_if) begin
        r_bus_addr  <= if_addr;
        r_bus_we    <= 1'b0;
        r_bus_wdata <= '0;
      end
      if (w_done_if) begin
        r_if_rdata <= bus_rdata;
      end
      if (w_done_mem && !r_bus_we) begin
        r_mem_rdata <= bus_rdata;
      end
    end
  end

  assign if_ack    = r_if_ack;
  assign mem_ack   = r_mem_ack;
  assign if_rdata  = r_if_rdata;
  assign mem_rdata = r_mem_rdata;
  assign bus_we    = r_bus_we;
  assign bus_addr  = r_bus_addr;
  assign bus_wdata = r_bus_wdata;
  assign if_stall  = if_req & ~r_if_ack;
  assign mem_stall = mem_req & ~r_mem_ack;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scenario and randomized checks of mem_arbiter against a transfer-level model
module tb_mem_arbiter;

  localparam int MAXS = 4;

  logic        clk       = 1'b0;
  logic        rst       = 1'b0;
  logic        if_req    = 1'b0;
  logic [31:0] if_addr   = '0;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        if_stall;
  logic        mem_req   = 1'b0;
  logic        mem_we    = 1'b0;
  logic [31:0] mem_addr  = '0;
  logic [31:0] mem_wdata = '0;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        mem_stall;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ready = 1'b0;
  logic [31:0] bus_rdata = '0;

  always #5 clk = ~clk;

  mem_arbiter #(.MAX_MEM_STREAK(MAXS)) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_ack    (if_ack),
    .if_stall  (if_stall),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .mem_stall (mem_stall),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_ready (bus_ready),
    .bus_rdata (bus_rdata)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
  endtask

  // Reference model: who owns the bus (0 none, 1 IF, 2 MEM) and what each requester should see.
  int          m_owner;
  int          m_streak;
  logic        m_we;
  logic        m_if_ack;
  logic        m_mem_ack;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_if_rdata;
  logic [31:0] m_mem_rdata;
  logic [31:0] words [16];

  task automatic model_reset();
    m_owner     = 0;
    m_streak    = 0;
    m_we        = 1'b0;
    m_if_ack    = 1'b0;
    m_mem_ack   = 1'b0;
    m_addr      = '0;
    m_wdata     = '0;
    m_if_rdata  = '0;
    m_mem_rdata = '0;
  endtask

  task automatic model_step();
    int pick;
    bit guard;
    bit done;
    pick  = 0;
    guard = 1'b0;
    done  = (m_owner != 0) && bus_ready;
    m_if_ack  = done && (m_owner == 1);
    m_mem_ack = done && (m_owner == 2);
    if (m_if_ack) m_if_rdata = bus_rdata;
    if (m_mem_ack && !m_we) m_mem_rdata = bus_rdata;
    if (done && m_we) words[m_addr[5:2]] = m_wdata;
    if (done) begin
      m_owner = 0;
    end else if (m_owner == 0) begin
`ifdef MEM_ARBITER_STARVE_GUARD_EN
      guard = if_req && (m_streak >= MAXS);
`endif
      if (guard || (if_req && !mem_req)) pick = 1;
      else if (mem_req) pick = 2;
      if (pick == 1) begin
        m_addr = if_addr; m_we = 1'b0; m_wdata = '0;
      end else if (pick == 2) begin
        m_addr = mem_addr; m_we = mem_we; m_wdata = mem_wdata;
      end
      if (!if_req || pick == 1) m_streak = 0;
      else if (pick == 2 && m_streak < MAXS) m_streak++;
      m_owner = pick;
    end
  endtask

  task automatic compare_regs();
    check_eq("bus_req",   bus_req,   m_owner != 0);
    check_eq("bus_addr",  bus_addr,  m_addr);
    check_eq("bus_we",    bus_we,    m_we);
    check_eq("bus_wdata", bus_wdata, m_wdata);
    check_eq("if_ack",    if_ack,    m_if_ack);
    check_eq("mem_ack",   mem_ack,   m_mem_ack);
    check_eq("if_rdata",  if_rdata,  m_if_rdata);
    check_eq("mem_rdata", mem_rdata, m_mem_rdata);
  endtask

  task automatic tick();
    #1;
    check_eq("if_stall",  if_stall,  if_req & ~m_if_ack);
    check_eq("mem_stall", mem_stall, mem_req & ~m_mem_ack);
    model_step();
    @(negedge clk);
    compare_regs();
  endtask

  int  n_xfer;
  int  cyc;
  bit  exp_if;

  initial begin
    for (int i = 0; i < 16; i++) words[i] = $urandom;
    model_reset();
    @(negedge clk);
    compare_regs();
    check_eq("rst_bus_req", bus_req, 0);
    rst = 1'b1;

    // Lone fetch, ready in first grant cycle
    if_req = 1'b1; if_addr = 32'h0000_0040; bus_ready = 1'b0;
    #1 check_eq("t24_stall_c0", if_stall, 1);
    tick();
    check_eq("t24_bus_addr", bus_addr, 32'h0000_0040);
    bus_ready = 1'b1; bus_rdata = 32'h2402_0005;
    #1 check_eq("t24_stall_c1", if_stall, 1);
    tick();
    check_eq("t24_ack", if_ack, 1);
    check_eq("t24_rdata", if_rdata, 32'h2402_0005);
    if_req = 1'b0; bus_ready = 1'b0;
    tick();
    check_eq("t24_ack_once", if_ack, 0);

    // Simultaneous requests: MEM first
    if_req = 1'b1; if_addr = 32'h40; mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h1000;
    tick();
    check_eq("t25_mem_first", bus_addr, 32'h1000);
    bus_ready = 1'b1; bus_rdata = 32'h1111_2222;
    tick();
    check_eq("t25_mem_ack", mem_ack, 1);
    check_eq("t25_mem_rdata", mem_rdata, 32'h1111_2222);
    mem_req = 1'b0; bus_ready = 1'b0;
    tick();
    check_eq("t25_if_addr", bus_addr, 32'h40);
    bus_ready = 1'b1; bus_rdata = 32'h3333_4444;
    tick();
    check_eq("t25_if_ack", if_ack, 1);
    check_eq("t25_if_rdata", if_rdata, 32'h3333_4444);
    if_req = 1'b0; bus_ready = 1'b0;
    tick();

    // Write with three wait cycles
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h1004; mem_wdata = 32'hDEAD_BEEF;
    bus_rdata = 32'h5555_AAAA;
    tick();
    for (int i = 0; i < 4; i++) begin
      check_eq("t26_we", bus_we, 1);
      check_eq("t26_wdata", bus_wdata, 32'hDEAD_BEEF);
      check_eq("t26_addr", bus_addr, 32'h1004);
      bus_ready = (i == 3);
      tick();
    end
    check_eq("t26_ack", mem_ack, 1);
    check_eq("t26_rdata_kept", mem_rdata, 32'h1111_2222);
    mem_req = 1'b0; mem_we = 1'b0; bus_ready = 1'b0;
    tick();
    check_eq("t26_ack_once", mem_ack, 0);

    // Reset during a MEM grant
    mem_req = 1'b1; mem_addr = 32'h2000;
    tick();
    check_eq("t27_granted", bus_req, 1);
    tick();
    rst = 1'b0;
    model_reset();
    #1 check_eq("t27_bus_req_drop", bus_req, 0);
    compare_regs();
    @(negedge clk);
    compare_regs();
    rst = 1'b1;
    tick();
    check_eq("t27_no_ack", mem_ack, 0);
    check_eq("t27_regrant", bus_req, 1);
    bus_ready = 1'b1; bus_rdata = 32'h7777_8888;
    tick();
    check_eq("t27_ack", mem_ack, 1);
    mem_req = 1'b0; bus_ready = 1'b0;
    tick();

    // bus_ready while idle
    bus_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("t29_no_if_ack", if_ack, 0);
      check_eq("t29_no_mem_ack", mem_ack, 0);
      check_eq("t29_idle", bus_req, 0);
    end
    bus_ready = 1'b0;

    // Both requests held high throughout
    if_req = 1'b1; if_addr = 32'h80; mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h3000;
    n_xfer = 0;
    cyc = 0;
    while (n_xfer < 10 && cyc < 200) begin
      bus_ready = (m_owner != 0);
      bus_rdata = $urandom;
      tick();
      cyc++;
      if (if_ack || mem_ack) begin
`ifdef MEM_ARBITER_STARVE_GUARD_EN
        exp_if = (n_xfer % 5 == 4);
`else
        exp_if = 1'b0;
`endif
        check_eq("t28_owner_is_if", if_ack, exp_if);
        n_xfer++;
      end
    end
    check_eq("t28_transfers", n_xfer, 10);
    if_req = 1'b0; mem_req = 1'b0; bus_ready = 1'b0;
    tick();

    // Randomized traffic
    for (int c = 0; c < 2500; c++) begin
      if (c % 700 == 350) begin
        rst = 1'b0; if_req = 1'b0; mem_req = 1'b0;
        model_reset();
        #1 compare_regs();
        @(negedge clk);
        rst = 1'b1;
      end
      if (m_if_ack) if_req = 1'b0;
      else if (!if_req && $urandom_range(0, 2) == 0) begin
        if_req = 1'b1; if_addr = $urandom;
      end
      if (m_mem_ack) mem_req = 1'b0;
      else if (!mem_req && $urandom_range(0, 2) == 0) begin
        mem_req = 1'b1; mem_we = $urandom_range(0, 1) == 1;
        mem_addr = $urandom; mem_wdata = $urandom;
      end
      if (m_owner != 0) bus_ready = $urandom_range(0, 2) == 0;
      else bus_ready = $urandom_range(0, 3) == 0;
      bus_rdata = (m_owner != 0 && !m_we) ? words[m_addr[5:2]] : $urandom;
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
